uart_boot_loader: RTL and testbench

// - Downstream consumer of the UART RX FIFO. Parses framed byte stream, writes 32-bit words into MEMORY, then releases CORE.
// - Replaces the bare 0xFF "start" byte with checksummed load/run frames; core_run gates CORE clock enable at top level.
// - Frame: SYNC(0xA5) CMD [ADDR_LO ADDR_HI LEN DATA*4*LEN] CSUM; CMD 0x01=WRITE (bracketed fields), 0x02=RUN (no fields).

---
 rtl/uart_boot_pkg.sv | 30 +++
 rtl/uart_boot_loader_if.sv | 31 +++
 rtl/uart_byte_fetch.sv | 43 ++++
 rtl/uart_boot_loader.sv | 192 +++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_boot_pkg.sv
// ---------------------------------------------------------------------------
// uart_boot_pkg
// Shared definitions for the UART boot loader: the parser state encoding,
// the framing byte values and the checksum test.
// ---------------------------------------------------------------------------
package uart_boot_pkg;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        CMD    = 3'd1,
        ADDR_L = 3'd2,
        ADDR_H = 3'd3,
        LEN    = 3'd4,
        DATA   = 3'd5,
        CSUM   = 3'd6
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;

    // A frame is good when the running sum plus the trailing checksum byte
    // wraps to zero.
    function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
        logic [7:0] total;
        total = sum + csum;
        return (total == 8'h00);
    endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// ---------------------------------------------------------------------------
// uart_boot_loader_if
// Bundles the RX FIFO read port and the RAM write port of the boot loader.
//   fifo_empty  FIFO empty flag            (into loader)
//   fifo_q      FIFO data, non-show-ahead  (into loader)
//   fifo_rdreq  FIFO read request          (from loader)
//   ram_addr    RAM word address           (from loader)
//   ram_wdata   RAM write data             (from loader)
//   ram_we      RAM write enable pulse     (from loader)
// master = the loader, slave = the FIFO/RAM side.
// ---------------------------------------------------------------------------
interface uart_boot_loader_if #(
    parameter int ADDR_W = 13
);
    logic              fifo_empty;
    logic [7:0]        fifo_q;
    logic              fifo_rdreq;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;

    modport master (
        input  fifo_empty, fifo_q,
        output fifo_rdreq, ram_addr, ram_wdata, ram_we
    );

    modport slave (
        output fifo_empty, fifo_q,
        input  fifo_rdreq, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/uart_byte_fetch.sv
// ---------------------------------------------------------------------------
// uart_byte_fetch
// Pulls bytes out of a non-show-ahead FIFO: a read request is issued only
// when the FIFO holds data and no read is outstanding, so the data returned
// one cycle later is presented as a single-cycle byte_valid strobe.
// Throughput is at most one byte every two cycles.
//   clk, rst_n    clock, synchronous active-low reset
//   fifo_empty_i  FIFO empty flag
//   fifo_q_i      FIFO read data (valid the cycle after the request)
//   fifo_rdreq_o  FIFO read request
//   byte_valid_o  byte_o carries a fresh byte this cycle
//   byte_o        fetched byte
// ---------------------------------------------------------------------------
module uart_byte_fetch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_q_i,
    output logic       fifo_rdreq_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_o
);

    logic rd_pend_q;
    logic rd_pend_d;

    // Requests are held off during reset so no byte is consumed and lost
    // while the parser is being cleared.
    assign fifo_rdreq_o = rst_n && !fifo_empty_i && !rd_pend_q;
    assign rd_pend_d    = fifo_rdreq_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    assign byte_valid_o = rd_pend_q;
    assign byte_o       = fifo_q_i;

endmodule

// File: rtl/uart_boot_loader.sv
// ---------------------------------------------------------------------------
// uart_boot_loader
// Parses checksummed frames from the UART RX FIFO:
//   A5 01 ADDR_LO ADDR_HI LEN DATA*4*LEN CSUM   write LEN words (0 = 256)
//   A5 02 CSUM                                  release the core
// Words are assembled little-endian and written to RAM one per pulse.
//   clk, rst_n   clock, synchronous active-low reset
//   bus          FIFO read port and RAM write port (master modport)
//   core_run     sticky, core may run
//   busy         parser is inside a frame
//   err_csum     sticky checksum / format error
//   err_timeout  one-cycle pulse when a frame stalls too long
// ---------------------------------------------------------------------------
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int ADDR_W      = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_boot_loader_if.master  bus,
    output logic                core_run,
    output logic                busy,
    output logic                err_csum,
    output logic                err_timeout
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic              byte_valid;
    logic [7:0]        byte_in;
    logic              rdreq;

    state_e            state_q;
    logic [7:0]        sum_q;
    logic [7:0]        addr_lo_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wcnt_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       word_q;
    logic              is_run_q;
    logic [IDLE_W-1:0] idle_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic              ram_we_q;
    logic              core_run_q;
    logic              err_csum_q;
    logic              err_timeout_q;

    logic [7:0]        sum_d;
    logic [31:0]       word_d;
    logic [IDLE_W-1:0] idle_d;

    uart_byte_fetch u_fetch (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty_i (bus.fifo_empty),
        .fifo_q_i     (bus.fifo_q),
        .fifo_rdreq_o (rdreq),
        .byte_valid_o (byte_valid),
        .byte_o       (byte_in)
    );

    always_comb begin
        sum_d  = sum_q + byte_in;
        // New byte enters at the top; after four bytes the first one sits
        // in bits [7:0].
        word_d = {byte_in, word_q};
        idle_d = idle_q + IDLE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            sum_q         <= '0;
            addr_lo_q     <= '0;
            addr_q        <= '0;
            wcnt_q        <= '0;
            byte_idx_q    <= '0;
            word_q        <= '0;
            is_run_q      <= 1'b0;
            idle_q        <= '0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            ram_we_q      <= 1'b0;
            core_run_q    <= 1'b0;
            err_csum_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            ram_we_q      <= 1'b0;
            err_timeout_q <= 1'b0;
            // A byte arriving on the expiry cycle takes priority over the
            // timeout.
            if (byte_valid) begin
                idle_q <= '0;
                case (state_q)
                    HUNT: begin
                        if (byte_in == SYNC_BYTE) begin
                            state_q <= CMD;
                            sum_q   <= '0;
                        end
                    end
                    CMD: begin
                        sum_q <= sum_d;
                        if (byte_in == CMD_WRITE) begin
                            is_run_q <= 1'b0;
                            state_q  <= ADDR_L;
                        end else if (byte_in == CMD_RUN) begin
                            is_run_q <= 1'b1;
                            state_q  <= CSUM;
                        end else begin
                            err_csum_q <= 1'b1;
                            state_q    <= HUNT;
                        end
                    end
                    ADDR_L: begin
                        sum_q     <= sum_d;
                        addr_lo_q <= byte_in;
                        state_q   <= ADDR_H;
                    end
                    ADDR_H: begin
                        sum_q <= sum_d;
                        // Only 13 address bits exist; anything above is a
                        // malformed frame.
                        if (byte_in[7:5] != 3'b000) begin
                            err_csum_q <= 1'b1;
                            state_q    <= HUNT;
                        end else begin
                            addr_q  <= ADDR_W'({byte_in[4:0], addr_lo_q});
                            state_q <= LEN;
                        end
                    end
                    LEN: begin
                        sum_q      <= sum_d;
                        // LEN=0 wraps to 255 remaining, i.e. 256 words.
                        wcnt_q     <= byte_in - 8'd1;
                        byte_idx_q <= '0;
                        state_q    <= DATA;
                    end
                    DATA: begin
                        sum_q      <= sum_d;
                        word_q     <= word_d[31:8];
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            ram_wdata_q <= word_d;
                            ram_addr_q  <= addr_q;
                            ram_we_q    <= 1'b1;
                            addr_q      <= addr_q + ADDR_W'(1);
                            if (wcnt_q == 8'd0) begin
                                state_q <= CSUM;
                            end else begin
                                wcnt_q <= wcnt_q - 8'd1;
                            end
                        end
                    end
                    CSUM: begin
                        if (csum_ok(sum_q, byte_in)) begin
                            if (is_run_q && !err_csum_q) begin
                                core_run_q <= 1'b1;
                            end
                        end else begin
                            err_csum_q <= 1'b1;
                        end
                        state_q <= HUNT;
                    end
                    default: state_q <= HUNT;
                endcase
            end else if (state_q != HUNT) begin
                if (idle_d == IDLE_W'(TIMEOUT_CYC)) begin
                    idle_q        <= '0;
                    err_timeout_q <= 1'b1;
                    state_q       <= HUNT;
                end else begin
                    idle_q <= idle_d;
                end
            end else begin
                idle_q <= '0;
            end
        end
    end

    assign bus.fifo_rdreq = rdreq;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.ram_we     = ram_we_q;
    assign core_run       = core_run_q;
    assign err_csum       = err_csum_q;
    assign err_timeout    = err_timeout_q;
    assign busy           = (state_q != HUNT);

endmodule

// File: tb/tb_uart_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_boot_loader
// Directed frame table, hand-written reset/timeout sequences and randomized
// frames checked against a frame-level model of the loader.
// ---------------------------------------------------------------------------
module tb_uart_boot_loader;
    import uart_boot_pkg::*;

    localparam int TO = 300;
    localparam int AW = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_boot_loader_if #(.ADDR_W(AW)) bus();
    logic core_run, busy, err_csum, err_timeout;

    uart_boot_loader #(.TIMEOUT_CYC(TO), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .core_run    (core_run),
        .busy        (busy),
        .err_csum    (err_csum),
        .err_timeout (err_timeout)
    );

    // FIFO model: initial block owns wp, the pop process owns rp.
    logic [7:0] fmem [0:4095];
    int wp = 0;
    int rp = 0;
    assign bus.fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (bus.fifo_rdreq) begin
            bus.fifo_q <= fmem[rp % 4096];
            rp <= rp + 1;
        end
    end

    typedef struct packed {
        logic [12:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t obs[$];
    wr_t exp_q[$];
    int tcnt = 0;
    int bad_rd = 0;

    always @(negedge clk) begin
        if (bus.ram_we) obs.push_back({bus.ram_addr, bus.ram_wdata});
        if (err_timeout) tcnt <= tcnt + 1;
        if (bus.fifo_rdreq && bus.fifo_empty) bad_rd <= bad_rd + 1;
    end

    int checks = 0;
    int errors = 0;
    int cidx = 0;
    logic [31:0] wbuf [0:255];
    bit err_m, run_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wp % 4096] = b;
        wp = wp + 1;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [15:0] a16,
                              input logic [7:0] len, input bit bad, input int noise);
        logic [7:0] s;
        logic [7:0] b;
        int n;
        @(posedge clk); #2;
        for (int i = 0; i < noise; i++) push(i[0] ? 8'hFF : 8'h00);
        push(SYNC_BYTE);
        push(cmd);
        s = cmd;
        if (cmd == CMD_WRITE) begin
            push(a16[7:0]);
            push(a16[15:8]);
            push(len);
            s = s + a16[7:0] + a16[15:8] + len;
            n = (len == 8'd0) ? 256 : int'(len);
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    b = wbuf[i][8*k +: 8];
                    push(b);
                    s = s + b;
                end
            end
        end
        s = 8'h00 - s;
        if (bad) s = s + 8'h01;
        push(s);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (rp != wp && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain"}, 32'(rp == wp), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_writes(input string name);
        check({name, "_nwr"}, obs.size(), exp_q.size());
        for (int i = cidx; i < exp_q.size() && i < obs.size(); i++) begin
            check({name, "_wa"}, 32'(obs[i].a), 32'(exp_q[i].a));
            check({name, "_wd"}, obs[i].d, exp_q[i].d);
        end
        cidx = exp_q.size();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        logic [7:0]  cmd;
        logic [15:0] a16;
        logic [7:0]  len;
        logic [31:0] w0;
        bit          bad;
        bit          e_err;
        bit          e_run;
        int          e_nw;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int t0;
        bit seen;
        tbl[0] = '{1'b1, 8'h01, 16'h0010, 8'd1, 32'h11223344, 1'b0, 1'b0, 1'b0, 1};
        tbl[1] = '{1'b0, 8'h02, 16'h0000, 8'd0, 32'h0,        1'b0, 1'b0, 1'b1, 0};
        tbl[2] = '{1'b1, 8'h01, 16'h0010, 8'd1, 32'h11223344, 1'b1, 1'b1, 1'b0, 1};
        tbl[3] = '{1'b0, 8'h02, 16'h0000, 8'd0, 32'h0,        1'b0, 1'b1, 1'b0, 0};
        tbl[4] = '{1'b1, 8'h01, 16'h1FFF, 8'd2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 2};
        tbl[5] = '{1'b1, 8'h01, 16'h2000, 8'd1, 32'h01020304, 1'b0, 1'b1, 1'b0, 0};
        tbl[6] = '{1'b1, 8'h07, 16'h0000, 8'd0, 32'h0,        1'b0, 1'b1, 1'b0, 0};
        tbl[7] = '{1'b0, 8'h02, 16'h0000, 8'd0, 32'h0,        1'b0, 1'b1, 1'b0, 0};
        tbl[8] = '{1'b1, 8'h01, 16'h0100, 8'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 256};
        tbl[9] = '{1'b0, 8'h02, 16'h0000, 8'd0, 32'h0,        1'b0, 1'b0, 1'b1, 0};

        // Reset state, with the FIFO held empty.
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdreq", 32'(bus.fifo_rdreq), 32'd0);
        check("rst_we", 32'(bus.ram_we), 32'd0);
        check("rst_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_wdata", bus.ram_wdata, 32'd0);
        check("rst_run", 32'(core_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_errc", 32'(err_csum), 32'd0);
        check("rst_errt", 32'(err_timeout), 32'd0);
        repeat (40) @(negedge clk);
        check("empty_rdreq", 32'(bad_rd), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);

        // Directed frame table, noise bytes 00 FF ahead of every sync.
        for (int v = 0; v < 10; v++) begin
            if (tbl[v].rst) do_reset();
            for (int i = 0; i < 256; i++) wbuf[i] = tbl[v].w0 + 32'(i);
            for (int i = 0; i < tbl[v].e_nw; i++)
                exp_q.push_back({13'((int'(tbl[v].a16) + i) % 8192), tbl[v].w0 + 32'(i)});
            send_frame(tbl[v].cmd, tbl[v].a16, tbl[v].len, tbl[v].bad, 2);
            wait_drain($sformatf("vec%0d", v));
            check_writes($sformatf("vec%0d", v));
            check($sformatf("vec%0d_err", v), 32'(err_csum), 32'(tbl[v].e_err));
            check($sformatf("vec%0d_run", v), 32'(core_run), 32'(tbl[v].e_run));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
        end

        // Timeout: stall after A5 01 10, then a RUN frame still works.
        do_reset();
        @(posedge clk); #2;
        push(8'hA5); push(8'h01); push(8'h10);
        wait_drain("to_hdr");
        check("to_busy_pre", 32'(busy), 32'd1);
        t0 = tcnt;
        repeat (TO + 20) @(negedge clk);
        check("to_pulses", 32'(tcnt - t0), 32'd1);
        check("to_busy_post", 32'(busy), 32'd0);
        check("to_errc", 32'(err_csum), 32'd0);
        send_frame(CMD_RUN, 16'h0, 8'h0, 1'b0, 0);
        t0 = 0;
        while (rp != wp && t0 < 100) begin
            @(negedge clk);
            t0++;
        end
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (core_run) seen = 1'b1;
        end
        check("to_run_fast", 32'(seen), 32'd1);
        wait_drain("to_run");
        check("to_run_busy", 32'(busy), 32'd0);

        // Reset in the middle of DATA clears everything.
        do_reset();
        wbuf[0] = 32'hCAFEF00D;
        exp_q.push_back({13'h0033, 32'hCAFEF00D});
        send_frame(CMD_WRITE, 16'h0033, 8'd1, 1'b1, 0);
        wait_drain("mid_pre");
        check_writes("mid_pre");
        check("mid_pre_err", 32'(err_csum), 32'd1);
        @(posedge clk); #2;
        push(8'hA5); push(8'h01); push(8'h33); push(8'h00); push(8'h01);
        push(8'h11); push(8'h22);
        wait_drain("mid_part");
        check("mid_busy", 32'(busy), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rdreq", 32'(bus.fifo_rdreq), 32'd0);
        check("mid_we", 32'(bus.ram_we), 32'd0);
        check("mid_addr", 32'(bus.ram_addr), 32'd0);
        check("mid_wdata", bus.ram_wdata, 32'd0);
        check("mid_run", 32'(core_run), 32'd0);
        check("mid_busy0", 32'(busy), 32'd0);
        check("mid_errc", 32'(err_csum), 32'd0);
        check("mid_errt", 32'(err_timeout), 32'd0);
        #2 rst_n = 1'b1;
        check_writes("mid_post");

        // Randomized frames against the frame-level model.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            err_m = 1'b0;
            run_m = 1'b0;
            for (int f = 0; f < 10; f++) begin
                bit is_run, bad;
                logic [15:0] a16;
                logic [7:0] len;
                is_run = ($urandom_range(0, 3) == 0);
                bad = ($urandom_range(0, 7) == 0);
                a16 = 16'($urandom_range(0, 8191));
                len = 8'($urandom_range(1, 4));
                for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
                if (is_run) begin
                    if (bad) err_m = 1'b1;
                    else if (!err_m) run_m = 1'b1;
                    send_frame(CMD_RUN, 16'h0, 8'h0, bad, $urandom_range(0, 2));
                end else begin
                    for (int i = 0; i < int'(len); i++)
                        exp_q.push_back({13'((int'(a16) + i) % 8192), wbuf[i]});
                    if (bad) err_m = 1'b1;
                    send_frame(CMD_WRITE, a16, len, bad, $urandom_range(0, 2));
                end
                wait_drain("rnd");
                check_writes("rnd");
                check("rnd_err", 32'(err_csum), 32'(err_m));
                check("rnd_run", 32'(core_run), 32'(run_m));
                check("rnd_busy", 32'(busy), 32'd0);
            end
        end

        check("never_rd_empty", 32'(bad_rd), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
